// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24 h HH:MM:SS timekeeper with N_ALARMS armable alarms, up/down
// editing, a shared registered 4-digit BCD display and a ring/snooze/stop state machine.
module multi_alarm_clock #(
  parameter int N_ALARMS   = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 1,
  localparam int SEL_W     = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                funct_clk,
  input  logic                rst,
  input  logic                sec_tick,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    alarm_sel,
  input  logic                ENH,
  input  logic                ENM,
  input  logic                up,
  input  logic                down,
  input  logic                arm_toggle,
  input  logic                snooze,
  input  logic                stop,
  output logic [1:0]          H1,
  output logic [3:0]          H2,
  output logic [2:0]          M1,
  output logic [3:0]          M2,
  output logic [N_ALARMS-1:0] armed,
  output logic                ring,
  output logic [SEL_W-1:0]    ring_id
);

  typedef enum logic [1:0] {IDLE, RING, SNOOZE} ring_state_t;

  localparam logic [SEL_W:0] N_SEL      = (SEL_W + 1)'(N_ALARMS);
  localparam logic [5:0]     RING_MIN_L = 6'(RING_MIN);
  localparam logic [6:0]     SNOOZE_L   = 7'(SNOOZE_MIN);

  logic [4:0]       hour_q, nxt_hour, edit_hour, dl_hour, snz_hour, disp_hour;
  logic [5:0]       min_q, nxt_min, edit_min, dl_min, snz_min, disp_min;
  logic [5:0]       sec_q, nxt_sec;
  logic [6:0]       snz_sum;
  logic [4:0]       alarm_hour [N_ALARMS];
  logic [5:0]       alarm_min  [N_ALARMS];
  logic [SEL_W-1:0] sel, match_id;
  logic             time_edit_mode, alarm_edit_mode, field_edit;
  logic             rollover, match_hit, match, force_idle;
  ring_state_t      state;
  logic [5:0]       ring_timer;

  function automatic logic [4:0] step_hour(input logic [4:0] h, input logic inc);
    if (inc) return (h == 5'd23) ? 5'd0 : h + 5'd1;
    return (h == 5'd0) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] step_min(input logic [5:0] m, input logic inc);
    if (inc) return (m == 6'd59) ? 6'd0 : m + 6'd1;
    return (m == 6'd0) ? 6'd59 : m - 6'd1;
  endfunction

  function automatic logic [2:0] tens_of(input logic [5:0] v);
    if (v >= 6'd50) return 3'd5;
    if (v >= 6'd40) return 3'd4;
    if (v >= 6'd30) return 3'd3;
    if (v >= 6'd20) return 3'd2;
    if (v >= 6'd10) return 3'd1;
    return 3'd0;
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    return 4'(v - 6'd10 * {3'b000, tens_of(v)});
  endfunction

  // Out-of-range selections fall back to alarm 0.
  assign sel             = ({1'b0, alarm_sel} < N_SEL) ? alarm_sel : '0;
  assign time_edit_mode  = (mode == 2'b01);
  assign alarm_edit_mode = (mode == 2'b10);
  assign field_edit      = (up != down) && (ENH || ENM);

  always_comb begin
    nxt_hour = hour_q;
    nxt_min  = min_q;
    nxt_sec  = sec_q;
    rollover = 1'b0;
    if (time_edit_mode) begin
      if (field_edit) begin
        nxt_sec = '0;
        if (ENH) nxt_hour = step_hour(hour_q, up);
        else     nxt_min  = step_min(min_q, up);
      end
    end else if (sec_tick) begin
      if (sec_q == 6'd59) begin
        nxt_sec  = '0;
        rollover = 1'b1;
        if (min_q == 6'd59) begin
          nxt_min  = '0;
          nxt_hour = step_hour(hour_q, 1'b1);
        end else begin
          nxt_min = min_q + 6'd1;
        end
      end else begin
        nxt_sec = sec_q + 6'd1;
      end
    end
  end

  always_comb begin
    edit_hour = alarm_hour[sel];
    edit_min  = alarm_min[sel];
    if (ENH) edit_hour = step_hour(alarm_hour[sel], up);
    else     edit_min  = step_min(alarm_min[sel], up);
  end

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    match_hit = 1'b0;
    match_id  = '0;
    for (int k = N_ALARMS - 1; k >= 0; k--) begin
      if (armed[k] && alarm_hour[k] == nxt_hour && alarm_min[k] == nxt_min) begin
        match_hit = 1'b1;
        match_id  = SEL_W'(k);
      end
    end
    match = rollover && match_hit;
  end

  always_comb begin
    snz_sum  = {1'b0, min_q} + SNOOZE_L;
    snz_hour = hour_q;
    snz_min  = snz_sum[5:0];
    if (snz_sum >= 7'd60) begin
      snz_min  = 6'(snz_sum - 7'd60);
      snz_hour = step_hour(hour_q, 1'b1);
    end
  end

  assign force_idle = time_edit_mode ||
                      (alarm_edit_mode && arm_toggle && state != IDLE &&
                       sel == ring_id && armed[sel]);

  // Time, alarm registers and the display latch, all from the same next-state values.
  always_ff @(posedge funct_clk) begin
    if (rst) begin
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      armed     <= '0;
      disp_hour <= '0;
      disp_min  <= '0;
      for (int k = 0; k < N_ALARMS; k++) begin
        alarm_hour[k] <= '0;
        alarm_min[k]  <= '0;
      end
    end else begin
      hour_q <= nxt_hour;
      min_q  <= nxt_min;
      sec_q  <= nxt_sec;
      if (alarm_edit_mode) begin
        if (field_edit) begin
          alarm_hour[sel] <= edit_hour;
          alarm_min[sel]  <= edit_min;
        end
        if (arm_toggle) armed[sel] <= ~armed[sel];
        disp_hour <= field_edit ? edit_hour : alarm_hour[sel];
        disp_min  <= field_edit ? edit_min  : alarm_min[sel];
      end else begin
        disp_hour <= nxt_hour;
        disp_min  <= nxt_min;
      end
    end
  end

  // Ring state machine; ring_timer counts the minute rollovers left before auto-off.
  always_ff @(posedge funct_clk) begin
    if (rst) begin
      state      <= IDLE;
      ring       <= 1'b0;
      ring_id    <= '0;
      ring_timer <= '0;
      dl_hour    <= '0;
      dl_min     <= '0;
    end else if (force_idle) begin
      state <= IDLE;
      ring  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state      <= RING;
            ring       <= 1'b1;
            ring_id    <= match_id;
            ring_timer <= RING_MIN_L;
          end
        end
        RING: begin
          if (stop) begin
            state <= IDLE;
            ring  <= 1'b0;
          end else if (snooze) begin
            state   <= SNOOZE;
            ring    <= 1'b0;
            dl_hour <= snz_hour;
            dl_min  <= snz_min;
          end else if (rollover) begin
            if (ring_timer <= 6'd1) begin
              state <= IDLE;
              ring  <= 1'b0;
            end else begin
              ring_timer <= ring_timer - 6'd1;
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state <= IDLE;
            ring  <= 1'b0;
          end else if (rollover && nxt_hour == dl_hour && nxt_min == dl_min) begin
            state      <= RING;
            ring       <= 1'b1;
            ring_timer <= RING_MIN_L;
          end
        end
        default: begin
          state <= IDLE;
          ring  <= 1'b0;
        end
      endcase
    end
  end

  assign H1 = 2'(tens_of({1'b0, disp_hour}));
  assign H2 = ones_of({1'b0, disp_hour});
  assign M1 = tens_of(disp_min);
  assign M2 = ones_of(disp_min);

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboard bench for multi_alarm_clock: a seconds-of-day reference model predicts the
// outputs after every edge; a separate monitor pops and compares them against the DUT.
module tb_multi_alarm_clock;

  localparam int N   = 4;
  localparam int SNZ = 5;
  localparam int RMIN = 1;

  logic       funct_clk = 1'b0;
  logic       rst = 1'b1, sec_tick = 1'b0, ENH = 1'b0, ENM = 1'b0, up = 1'b0, down = 1'b0;
  logic       arm_toggle = 1'b0, snooze = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00, alarm_sel = 2'b00;
  logic [1:0] H1;
  logic [3:0] H2;
  logic [2:0] M1;
  logic [3:0] M2;
  logic [N-1:0] armed;
  logic       ring;
  logic [1:0] ring_id;

  always #5 funct_clk = ~funct_clk;

  multi_alarm_clock #(.N_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_MIN(RMIN)) dut (
    .funct_clk(funct_clk), .rst(rst), .sec_tick(sec_tick), .mode(mode),
    .alarm_sel(alarm_sel), .ENH(ENH), .ENM(ENM), .up(up), .down(down),
    .arm_toggle(arm_toggle), .snooze(snooze), .stop(stop),
    .H1(H1), .H2(H2), .M1(M1), .M2(M2), .armed(armed), .ring(ring), .ring_id(ring_id)
  );

  typedef struct {
    bit rst; bit tick; logic [1:0] mode; int sel;
    bit enh; bit enm; bit up; bit down; bit tog; bit snz; bit stp;
  } stim_t;

  typedef struct {
    logic [12:0]  digits;
    logic [N-1:0] armed;
    logic         ring;
    logic [1:0]   rid;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds of day, alarms as minutes of day.
  int t = 0;
  int alarm_m[N];
  bit arm_b[N];
  bit ringing = 0, snoozing = 0;
  int rid = 0, rolls = 0, deadline = 0, disp = 0;

  task automatic model_step(input stim_t s);
    int sel, old_t, hit, h, m;
    bit rolled, active;
    bit old_arm[N];
    if (s.rst) begin
      t = 0; ringing = 0; snoozing = 0; rid = 0; disp = 0;
      for (int k = 0; k < N; k++) begin alarm_m[k] = 0; arm_b[k] = 0; end
      return;
    end
    sel = (s.sel < N) ? s.sel : 0;
    old_t = t;
    old_arm = arm_b;
    rolled = 0;
    if (s.mode == 2'b01) begin
      if (s.up != s.down) begin
        if (s.enh) t = ((t / 3600 + (s.up ? 1 : 23)) % 24) * 3600 + ((t / 60) % 60) * 60;
        else if (s.enm) t = (t / 3600) * 3600 + (((t / 60) % 60 + (s.up ? 1 : 59)) % 60) * 60;
      end
    end else if (s.tick) begin
      t = (t + 1) % 86400;
      rolled = (t % 60 == 0);
    end
    hit = -1;
    if (rolled)
      for (int k = N - 1; k >= 0; k--)
        if (old_arm[k] && alarm_m[k] == t / 60) hit = k;
    active = ringing || snoozing;
    if (s.mode == 2'b01 || (s.mode == 2'b10 && s.tog && active && sel == rid && old_arm[sel])) begin
      ringing = 0; snoozing = 0;
    end else if (!active) begin
      if (hit >= 0) begin ringing = 1; rid = hit; rolls = 0; end
    end else if (ringing) begin
      if (s.stp) ringing = 0;
      else if (s.snz) begin ringing = 0; snoozing = 1; deadline = (old_t / 60 + SNZ) % 1440; end
      else if (rolled) begin rolls++; if (rolls == RMIN) ringing = 0; end
    end else begin
      if (s.stp) snoozing = 0;
      else if (rolled && t / 60 == deadline) begin snoozing = 0; ringing = 1; rolls = 0; end
    end
    if (s.mode == 2'b10) begin
      if (s.up != s.down && (s.enh || s.enm)) begin
        h = alarm_m[sel] / 60; m = alarm_m[sel] % 60;
        if (s.enh) h = (h + (s.up ? 1 : 23)) % 24;
        else       m = (m + (s.up ? 1 : 59)) % 60;
        alarm_m[sel] = h * 60 + m;
      end
      if (s.tog) arm_b[sel] = !arm_b[sel];
    end
    disp = (s.mode == 2'b10) ? alarm_m[sel] : t / 60;
  endtask

  function automatic exp_t model_expect();
    exp_t e;
    int h, m;
    h = disp / 60; m = disp % 60;
    e.digits = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    for (int k = 0; k < N; k++) e.armed[k] = arm_b[k];
    e.ring = ringing;
    e.rid  = 2'(rid);
    return e;
  endfunction

  function automatic stim_t idle_stim(input logic [1:0] md);
    stim_t s;
    s = '{rst: 0, tick: 0, mode: md, sel: 0, enh: 0, enm: 0, up: 0, down: 0, tog: 0, snz: 0, stp: 0};
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s);
    @(negedge funct_clk);
    rst = s.rst; sec_tick = s.tick; mode = s.mode; alarm_sel = 2'(s.sel);
    ENH = s.enh; ENM = s.enm; up = s.up; down = s.down;
    arm_toggle = s.tog; snooze = s.snz; stop = s.stp;
    model_step(s);
    exp_q.push_back(model_expect());
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if ({H1, H2, M1, M2} !== e.digits) begin
      errors++;
      $display("[TB] FAIL digits: got %0d%0d:%0d%0d required %0d%0d:%0d%0d", H1, H2, M1, M2,
               e.digits[12:11], e.digits[10:7], e.digits[6:4], e.digits[3:0]);
    end
    checks++;
    if (armed !== e.armed) begin
      errors++;
      $display("[TB] FAIL armed: got %b required %b", armed, e.armed);
    end
    checks++;
    if (ring !== e.ring) begin
      errors++;
      $display("[TB] FAIL ring: got %b required %b at t=%0t", ring, e.ring, $time);
    end
    checks++;
    if (ring_id !== e.rid) begin
      errors++;
      $display("[TB] FAIL ring_id: got %0d required %0d", ring_id, e.rid);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge funct_clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic ticks(input logic [1:0] md, input int n);
    stim_t s;
    s = idle_stim(md);
    s.tick = 1;
    repeat (n) applyStimulus(s);
  endtask

  task automatic set_time(input int h, input int m);
    stim_t s;
    s = idle_stim(2'b01);
    s.enh = 1; s.up = 1;
    repeat ((h - t / 3600 + 24) % 24) applyStimulus(s);
    s.enh = 0; s.enm = 1;
    repeat ((m - (t / 60) % 60 + 60) % 60) applyStimulus(s);
    applyStimulus(s);
    s.up = 0; s.down = 1;
    applyStimulus(s);
  endtask

  task automatic set_alarm(input int k, input int h, input int m);
    stim_t s;
    s = idle_stim(2'b10);
    s.sel = k; s.enh = 1; s.up = 1;
    repeat ((h - alarm_m[k] / 60 + 24) % 24) applyStimulus(s);
    s.enh = 0; s.enm = 1;
    repeat ((m - alarm_m[k] % 60 + 60) % 60) applyStimulus(s);
  endtask

  task automatic arm_on(input int k);
    stim_t s;
    s = idle_stim(2'b10);
    s.sel = k; s.tog = 1;
    if (!arm_b[k]) applyStimulus(s);
  endtask

  task automatic ring_at_0730();
    set_time(7, 29);
    ticks(2'b00, 60);
    applyStimulus(idle_stim(2'b00));
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : driver
    stim_t s;
    int h, m, am, md, len;
    s = idle_stim(2'b00);
    s.rst = 1;
    applyStimulus(s);
    applyStimulus(s);
    applyStimulus(idle_stim(2'b00));

    ticks(2'b00, 60);
    set_time(23, 59);
    ticks(2'b00, 60);

    set_time(0, 15);
    s = idle_stim(2'b01); s.enh = 1; s.down = 1;
    applyStimulus(s);
    set_time(12, 59);
    s = idle_stim(2'b01); s.enm = 1; s.up = 1;
    applyStimulus(s);
    s.down = 1;
    applyStimulus(s);
    s.enh = 1;
    applyStimulus(s);

    set_alarm(2, 7, 30);
    set_alarm(0, 7, 30);
    arm_on(2);
    arm_on(0);

    ring_at_0730();
    s = idle_stim(2'b00); s.snz = 1;
    applyStimulus(s);
    ticks(2'b00, 299);
    applyStimulus(idle_stim(2'b00));
    ticks(2'b00, 1);
    applyStimulus(idle_stim(2'b00));
    s = idle_stim(2'b00); s.stp = 1;
    applyStimulus(s);

    ring_at_0730();
    ticks(2'b00, 62);

    ring_at_0730();
    s = idle_stim(2'b00); s.stp = 1; s.snz = 1;
    applyStimulus(s);
    ticks(2'b00, 310);

    ring_at_0730();
    applyStimulus(idle_stim(2'b01));
    applyStimulus(idle_stim(2'b00));

    ring_at_0730();
    s = idle_stim(2'b10); s.sel = 0; s.tog = 1;
    applyStimulus(s);
    arm_on(0);

    ring_at_0730();
    ticks(2'b00, 3);
    s = idle_stim(2'b10); s.rst = 1; s.tick = 1; s.stp = 1; s.up = 1; s.enh = 1;
    applyStimulus(s);
    applyStimulus(idle_stim(2'b00));

    h = $urandom_range(23);
    m = $urandom_range(59);
    set_time(h, m);
    for (int k = 0; k < N; k++) begin
      am = (h * 60 + m + $urandom_range(1, 20)) % 1440;
      set_alarm(k, am / 60, am % 60);
      arm_on(k);
    end
    for (int seg = 0; seg < 40; seg++) begin
      md = $urandom_range(99);
      len = $urandom_range(20, 150);
      for (int i = 0; i < len; i++) begin
        s = idle_stim((md < 75) ? 2'b00 : (md < 85) ? 2'b10 : (md < 93) ? 2'b11 : 2'b01);
        s.rst  = ($urandom_range(1999) == 0);
        s.tick = ($urandom_range(9) < 8);
        s.sel  = $urandom_range(N - 1);
        s.enh  = $urandom_range(1) == 1;
        s.enm  = $urandom_range(1) == 1;
        s.up   = ($urandom_range(29) == 0);
        s.down = ($urandom_range(29) == 0);
        s.tog  = ($urandom_range(49) == 0);
        s.snz  = ($urandom_range(39) == 0);
        s.stp  = ($urandom_range(79) == 0);
        applyStimulus(s);
      end
    end

    @(posedge funct_clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised successor to the single-alarm time/alarm block: one HH:MM:SS timekeeper plus N_ALARMS independently armed alarms, edited with up/down buttons and muxed onto a shared 4-digit display. A ring state machine provides snooze, stop and auto-timeout, replacing the old raw equality flag. Sits between the button debouncers / 1 Hz tick generator and the 7-segment driver.

## Interface
- N_ALARMS, 4: number of alarm registers, 1..8.
- SNOOZE_MIN, 5: snooze length in minutes, 1..59.
- RING_MIN, 1: ring auto-off after this many minutes, 1..59.
- funct_clk  in  1  system clock; everything is synchronous to it.
- rst  in  1  synchronous, active-high reset.
- sec_tick  in  1  one-cycle pulse per second.
- mode  in  2  00 run, 01 set time, 10 set alarm, 11 treated as 00.
- alarm_sel  in  clog2(N_ALARMS) (min 1)  alarm shown/edited in mode 10; values >= N_ALARMS select alarm 0.
- ENH, ENM  in  1 each  field enables for editing: hours, minutes.
- up, down  in  1 each  one-cycle edit pulses.
- arm_toggle  in  1  one-cycle pulse; in mode 10 toggles armed[alarm_sel].
- snooze, stop  in  1 each  one-cycle pulses from the user.
- H1 out 2, H2 out 4, M1 out 3, M2 out 4  BCD display digits.
- armed  out  N_ALARMS  per-alarm arm bits.
- ring  out  1  high while alarm sounds.
- ring_id  out  clog2(N_ALARMS)  index of the ringing/snoozed alarm.

## Operation
- Time format is 24 h BCD: H1 0-2, H2 0-9 (0-3 when H1=2), M1 0-5, M2 0-9; internal seconds 0-59.
- Run (mode 00): each sec_tick advances seconds; 59 s -> 00 with minute carry; 23:59:59 -> 00:00:00. up/down/arm_toggle ignored.
- Set time (mode 01): sec_tick ignored. up with ENH: hour +1, 23 -> 00; down: 00 -> 23. ENM: minute +/-1, 59 <-> 00, no carry into hours. Any edit clears seconds to 0. up and down in the same cycle: no change. ENH and ENM both high: hours only.
- Set alarm (mode 10): same edit rules on alarm[alarm_sel]; time keeps running on sec_tick.
- Display: mode 10 shows alarm[alarm_sel]; otherwise shows current time.
- Match: a sec_tick in mode 00/10 that makes time = HH:MM:00 equal to armed alarm k's HH:MM. Several simultaneous matches: lowest index wins.
- Ring FSM states IDLE, RING, SNOOZE:
  - IDLE -> RING on match; ring_id <= k; ring timer loaded RING_MIN.
  - RING -> IDLE on stop, or when RING_MIN minute rollovers elapse.
  - RING -> SNOOZE on snooze; snooze deadline = current HH:MM + SNOOZE_MIN (mod 24 h).
  - SNOOZE -> RING when a sec_tick makes time = deadline:00; ring timer reloaded. SNOOZE -> IDLE on stop.
  - Matches from other alarms in RING/SNOOZE are ignored.
  - Entering mode 01, or disarming ring_id alarm (arm_toggle), forces IDLE.
  - stop and snooze in the same cycle: stop wins.
- ring = 1 only in RING. ring_id holds its last value in IDLE.

## Timing
- All state registered on funct_clk; outputs are direct register decodes (no combinational input-to-output path).
- Digits update the cycle after the sec_tick or edit pulse that changes them.
- ring rises the cycle after the matching sec_tick; falls the cycle after stop/snooze/timeout/forced cancel.
- Reset: time 00:00:00, all alarms 00:00, armed = 0, FSM IDLE, ring = 0, ring_id = 0, display 00:00. rst mid-ring or mid-edit takes effect on the next edge and overrides all other inputs.
- Pulses longer than one cycle act once per cycle asserted; debouncing/edge detection is upstream.

## Test plan
- Reset then 60 sec_ticks in mode 00 -> display 00:01; from set 23:59 plus 60 ticks -> 00:00.
- Mode 01, ENH, down from 00:xx -> 23:xx; ENM, up from 12:59 -> 12:00; up+down together -> unchanged.
- Alarm 2 = 07:30 armed, alarm 0 = 07:30 armed, time 07:29:59, one tick -> ring = 1 next cycle, ring_id = 0.
- Ringing at 07:30, snooze (SNOOZE_MIN=5) -> ring = 0; ring re-asserts exactly on tick reaching 07:35:00; stop -> IDLE.
- Ring untouched -> ring drops on rollover to 07:31:00 (RING_MIN=1); stop+snooze same cycle -> IDLE, no snooze.
- Ring active, switch to mode 01 -> ring = 0 next cycle; rst during RING -> all outputs at reset values.
